// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

    // Bits needed to count 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// Combinational single-bit full adder cell driven by the serial controller.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: LSB-first feed of one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             cell_s, cell_co;
    logic             accept, last_bit;

    serial_fa_bit u_fa (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .ci (carry_reg),
        .s  (cell_s),
        .co (cell_co)
    );

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_bit = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)               state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_LAST)    state_next = DONE;
            DONE:    if (out_ready)              state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operands shift out LSB-first, sum bits enter at the MSB end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == SHIFT) begin
            a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
            b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
            sum_reg   <= {cell_s, sum_reg[WIDTH-1:1]};
            carry_reg <= cell_co;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= carry_reg ^ cell_co;
        end
    end

    assign ovf = ovf_reg;
`else
    logic unused_last_bit;
    assign unused_last_bit = last_bit;
`endif

    assign sum  = sum_reg;
    assign cout = carry_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed + random bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, s;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        s  = sx + sy + int'(c);
        return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endfunction

    // One full operation; bp = cycles of out_ready low after out_valid rises,
    // ign = keep in_valid high with a different a while shifting.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input int bp, input bit ign);
        logic [W:0] exp;
        exp = ref_add(xa, xb, xc);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        a         = xa;
        b         = xb;
        cin       = xc;
        out_ready = (bp == 0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_shift", busy, 1'b1);
            check("no_early_valid", out_valid, 1'b0);
            check("in_ready_shift", in_ready, 1'b0);
            in_valid = ign;
            if (ign) a = 8'h01;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid_latency", out_valid, 1'b1);
        check("busy_done", busy, 1'b0);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, ref_ovf(xa, xb, xc));
`endif
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_sum", sum, exp[W-1:0]);
            check("hold_cout", cout, exp[W]);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("back_idle", in_ready, 1'b1);
        check("valid_drop", out_valid, 1'b0);
        check("sum_kept", sum, exp[W-1:0]);
        $display("op a=%02h b=%02h cin=%0d bp=%0d ign=%0d -> sum=%02h cout=%0d (ref %02h/%0d)",
                 xa, xb, xc, bp, ign, sum, cout, exp[W-1:0], exp[W]);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        run_op(8'h5A, 8'h33, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 5, 1'b0);
        run_op(8'h44, 8'h11, 1'b1, 0, 1'b1);

        // Abort mid-shift with reset.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hC3;
        b        = 8'h5C;
        cin      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_sum", sum, '0);
        check("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_no_valid", out_valid, 1'b0);
        $display("op reset abort mid-shift -> in_ready=%0d out_valid=%0d sum=%02h", in_ready, out_valid, sum);
        run_op(8'h02, 8'h03, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        run_op(8'h40, 8'h10, 1'b0, 0, 1'b0);
`endif

        for (int k = 0; k < 16; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
